// File: rtl/maxunpool_stream_if.sv
// Output pixel stream of the unpool stage: data plus raster coordinates,
// with a valid/ready handshake.
interface maxunpool_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = 5
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         out_row;
  logic [CW-1:0]         out_col;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_row,
    output out_col,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/maxunpool_stream.sv
// Expands a pooled IN_SIZE x IN_SIZE map to 2*IN_SIZE x 2*IN_SIZE and streams it
// out in raster order, either nearest-neighbour or argmax-placed (max-unpool).
//
// state | meaning
// IDLE  | waiting for en; outputs zero
// RUN   | streaming pixels, one per accepted beat
// DONE  | one-cycle done_unpool pulse, then back to IDLE
module maxunpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_SIZE    = 14
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        en,
  input  logic                                        mode,
  input  logic [IN_SIZE-1:0][IN_SIZE-1:0][DATA_WIDTH-1:0] ifmap,
  input  logic [IN_SIZE-1:0][IN_SIZE-1:0][1:0]        idx,
  maxunpool_stream_if.master                          out_if,
  output logic                                        busy,
  output logic                                        done_unpool
);

  localparam int OUT_SIZE = 2 * IN_SIZE;
  localparam int CW       = $clog2(OUT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          mode_q, mode_d;

  logic                  run;
  logic [DATA_WIDTH-1:0] win_v;
  logic [1:0]            win_k;
  logic [DATA_WIDTH-1:0] pix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          mode_d  = mode;
        end
      end
      S_RUN: begin
        // valid is always high in RUN, so ready alone marks a transfer
        if (out_if.out_ready) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel is a pure function of registered counters/mode and the stable map
  always_comb begin
    win_v = ifmap[row_q[CW-1:1]][col_q[CW-1:1]];
    win_k = idx[row_q[CW-1:1]][col_q[CW-1:1]];
    pix   = win_v;
    if (mode_q && ({row_q[0], col_q[0]} != win_k)) begin
      pix = '0;
    end
  end

  assign run              = (state_q == S_RUN);
  assign busy             = run;
  assign done_unpool      = (state_q == S_DONE);
  assign out_if.out_valid = run;
  assign out_if.out_data  = run ? pix   : '0;
  assign out_if.out_row   = run ? row_q : '0;
  assign out_if.out_col   = run ? col_q : '0;

endmodule

// File: tb/tb_maxunpool_stream.sv
// Randomized self-checking bench for maxunpool_stream against a window-expansion
// reference model and a beat-ordered expected stream.
module tb_maxunpool_stream;

  localparam int DW       = 16;
  localparam int IN_SIZE  = 2;
  localparam int OUT_SIZE = 2 * IN_SIZE;
  localparam int CW       = $clog2(OUT_SIZE);
  localparam int TOTAL    = OUT_SIZE * OUT_SIZE;
  localparam int BUDGET   = 400;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic mode;
  logic [IN_SIZE-1:0][IN_SIZE-1:0][DW-1:0] ifmap;
  logic [IN_SIZE-1:0][IN_SIZE-1:0][1:0]    idx;
  logic busy;
  logic done_unpool;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_pix [TOTAL];

  maxunpool_stream_if #(.DATA_WIDTH(DW), .CW(CW)) sif ();

  maxunpool_stream #(.DATA_WIDTH(DW), .IN_SIZE(IN_SIZE)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .ifmap       (ifmap),
    .idx         (idx),
    .out_if      (sif.master),
    .busy        (busy),
    .done_unpool (done_unpool)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each pooled value fills its 2x2 window; in mode 1 only the argmax slot keeps it
  task automatic build_exp(input bit m);
    for (int i = 0; i < IN_SIZE; i++) begin
      for (int j = 0; j < IN_SIZE; j++) begin
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            exp_pix[(2*i+dr)*OUT_SIZE + 2*j+dc] =
              (!m || (int'(idx[i][j]) == dr*2+dc)) ? int'(ifmap[i][j]) : 0;
          end
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, sif.out_valid, 0);
    check({tag, "_data"},  sif.out_data,  0);
    check({tag, "_row"},   sif.out_row,   0);
    check({tag, "_col"},   sif.out_col,   0);
    check({tag, "_busy"},  busy,          0);
    check({tag, "_done"},  done_unpool,   0);
  endtask

  task automatic randomize_map();
    for (int i = 0; i < IN_SIZE; i++) begin
      for (int j = 0; j < IN_SIZE; j++) begin
        ifmap[i][j] = DW'($urandom);
        idx[i][j]   = 2'($urandom_range(0, 3));
      end
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE, so consecutive calls
  // start back-to-back. rmode 0: ready always high; 1: 3-cycle stall at beat 5
  // plus random toggling. noise drives en/mode randomly during RUN and DONE.
  task automatic do_run(input bit m, input int rmode, input bit noise, input int abort_at);
    int beats;
    int cyc;
    int stall;
    bit rdy;
    build_exp(m);
    beats = 0;
    cyc   = 0;
    stall = 0;
    en    = 1'b1;
    mode  = m;
    sif.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (beats < TOTAL && cyc < BUDGET) begin
      en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) mode = 1'($urandom_range(0, 1));
      check("valid", sif.out_valid, 1);
      check("busy", busy, 1);
      check("done_early", done_unpool, 0);
      check("data", sif.out_data, exp_pix[beats]);
      check("row", sif.out_row, beats / OUT_SIZE);
      check("col", sif.out_col, beats % OUT_SIZE);
      if (beats == abort_at) begin
        en = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_idle_valid", sif.out_valid, 0);
          check("abort_no_done", done_unpool, 0);
        end
        return;
      end
      if (rmode == 0) begin
        rdy = 1'b1;
      end else if (beats == 5 && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      sif.out_ready = rdy;
      if (rdy && sif.out_valid) beats++;
      @(negedge clk);
      cyc++;
    end
    check("beat_count", beats, TOTAL);
    en = noise;
    check("done_pulse", done_unpool, 1);
    check("done_valid", sif.out_valid, 0);
    check("done_busy", busy, 0);
    check("done_data", sif.out_data, 0);
    check("done_row", sif.out_row, 0);
    @(negedge clk);
    en = 1'b0;
    check("post_valid", sif.out_valid, 0);
    check("post_done_once", done_unpool, 0);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    sif.out_ready = 1'b0;
    ifmap = '0;
    idx   = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_valid", sif.out_valid, 0);
    end

    ifmap[0][0] = 16'd1;
    ifmap[0][1] = 16'd2;
    ifmap[1][0] = 16'd3;
    ifmap[1][1] = 16'd4;
    for (int i = 0; i < IN_SIZE; i++)
      for (int j = 0; j < IN_SIZE; j++) idx[i][j] = 2'($urandom_range(0, 3));
    do_run(1'b0, 0, 1'b0, -1);

    for (int i = 0; i < IN_SIZE; i++)
      for (int j = 0; j < IN_SIZE; j++) idx[i][j] = 2'b11;
    do_run(1'b1, 0, 1'b0, -1);
    for (int i = 0; i < IN_SIZE; i++)
      for (int j = 0; j < IN_SIZE; j++) idx[i][j] = 2'b00;
    do_run(1'b1, 0, 1'b0, -1);

    randomize_map();
    do_run(1'b0, 1, 1'b0, -1);
    randomize_map();
    do_run(1'b1, 1, 1'b0, -1);

    randomize_map();
    do_run(1'b1, 1, 1'b1, -1);
    randomize_map();
    do_run(1'b0, 1, 1'b1, -1);

    randomize_map();
    do_run(1'b0, 1, 1'b0, 7);
    do_run(1'b1, 0, 1'b0, -1);

    for (int n = 0; n < 6; n++) begin
      randomize_map();
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
